// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Result is computed at the start edge and held pending until the busy window ends.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dbg_state
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi, pend_lo;
    logic          pend_we;

    logic          is_start, is_mul, last;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   a_abs, b_abs, dvd, dvs, uq, ur;
    logic [31:0]   res_hi, res_lo;
    logic          res_we;

    assign busy      = (state == RUN);
    assign dbg_state = state;

    assign is_start = (state == IDLE) && (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign is_mul   = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign last     = (cnt == CW'(1));

    // One shared unsigned divider; signed divide runs on magnitudes and fixes signs after.
    // 0x80000000 / -1 falls out naturally: magnitude 2^31 re-signed positive wraps to 0x80000000.
    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'b0, a} * {32'b0, b};
        a_abs  = a[31] ? (~a + 32'd1) : a;
        b_abs  = b[31] ? (~b + 32'd1) : b;
        dvd    = (md_op == OP_DIV) ? a_abs : a;
        dvs    = (md_op == OP_DIV) ? b_abs : b;
        uq     = (dvs != 32'd0) ? (dvd / dvs) : 32'd0;
        ur     = (dvs != 32'd0) ? (dvd % dvs) : 32'd0;
    end

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_we = 1'b0;
        case (md_op)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_we = 1'b1;
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
                res_we = 1'b1;
            end
            OP_DIV: begin
                res_lo = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
                res_hi = a[31] ? (~ur + 32'd1) : ur;
                res_we = (b != 32'd0);
            end
            OP_DIVU: begin
                res_lo = uq;
                res_hi = ur;
                res_we = (b != 32'd0);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (is_start) state_nxt = RUN;
            RUN:     if (last)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // md_op is deliberately ignored while in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_we <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (is_start) begin
                    cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    pend_hi <= res_hi;
                    pend_lo <= res_lo;
                    pend_we <= res_we;
                end else if (md_op == OP_MTHI) begin
                    hi <= a;
                end else if (md_op == OP_MTLO) begin
                    lo <= a;
                end
            end else begin
                cnt <= cnt - CW'(1);
                if (last && pend_we) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed test-plan cases plus randomized ops
// checked against an arithmetic reference model of HI/LO and busy duration.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [2:0] NONE = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                           DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6, RSVD = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  md_op = NONE;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;
    logic        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .md_op(md_op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            MULT:  begin p = 64'(sx * sy); m_hi = p[63:32]; m_lo = p[31:0]; end
            MULTU: begin p = 64'(x) * 64'(y); m_hi = p[63:32]; m_lo = p[31:0]; end
            DIV:   if (y != 0) begin
                       q = sx / sy; r = sx % sy;
                       m_lo = q[31:0]; m_hi = r[31:0];
                   end
            DIVU:  if (y != 0) begin m_lo = x / y; m_hi = x % y; end
            MTHI:  m_hi = x;
            MTLO:  m_lo = x;
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge of the first idle cycle.
    task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input string name);
        int n, exp_n;
        md_op = op; a = x; b = y;
        @(posedge clk); #1;
        md_op = NONE;
        model(op, x, y);
        exp_n = (op == MULT || op == MULTU) ? MC : (op == DIV || op == DIVU) ? DC : 0;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n !== exp_n) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, exp_n);
        end
        n_checks++;
        if (hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL %s hilo: got hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || dbg_state !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b hi=%h lo=%h st=%b expected 0 0 0 0",
                     busy, hi, lo, dbg_state);
        end
    endtask

    task automatic test_mult();
        do_op(MULT, 32'hFFFFFFFF, 32'd2, "mult_neg1x2");
        n_checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
            n_fail++;
            $display("FAIL mult_const: got hi=%h lo=%h expected ffffffff fffffffe", hi, lo);
        end
        do_op(MULTU, 32'hFFFFFFFF, 32'd2, "multu");
        n_checks++;
        if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
            n_fail++;
            $display("FAIL multu_const: got hi=%h lo=%h expected 00000001 fffffffe", hi, lo);
        end
    endtask

    task automatic test_div();
        do_op(DIVU, 32'd7, 32'd2, "divu_7_2");
        n_checks++;
        if (hi !== 32'd1 || lo !== 32'd3) begin
            n_fail++;
            $display("FAIL divu_const: got hi=%h lo=%h expected 1 3", hi, lo);
        end
        do_op(DIV, 32'hFFFFFFF9, 32'd2, "div_m7_2");
        n_checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            n_fail++;
            $display("FAIL div_const: got hi=%h lo=%h expected ffffffff fffffffd", hi, lo);
        end
        do_op(DIV, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'h80000000) begin
            n_fail++;
            $display("FAIL div_ovf_const: got hi=%h lo=%h expected 0 80000000", hi, lo);
        end
    endtask

    task automatic test_div_zero();
        do_op(MTHI, 32'h1234, 32'd0, "mthi");
        do_op(MTLO, 32'h5678, 32'd0, "mtlo");
        do_op(DIV, 32'd99, 32'd0, "div_by_zero");
        do_op(DIVU, 32'd5, 32'd0, "divu_by_zero");
        n_checks++;
        if (hi !== 32'h1234 || lo !== 32'h5678) begin
            n_fail++;
            $display("FAIL divzero_const: got hi=%h lo=%h expected 1234 5678", hi, lo);
        end
    endtask

    task automatic test_reset_mid_run();
        md_op = DIV; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        md_op = NONE;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
        end
        repeat (DC) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_discard: got busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
        end
        do_op(MULT, 32'd6, 32'hFFFFFFFD, "mult_after_reset");
    endtask

    task automatic test_op_while_busy();
        int n;
        do_reset();
        md_op = MULT; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        model(MULT, 32'd3, 32'd4);
        md_op = MTHI; a = 32'hDEAD; b = 32'd0;
        @(posedge clk); #1;
        md_op = DIV; a = 32'd50; b = 32'd5;
        @(posedge clk); #1;
        md_op = NONE;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n !== MC - 2) begin
            n_fail++;
            $display("FAIL busy_ignore_cycles: got %0d expected %0d", n, MC - 2);
        end
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd12) begin
            n_fail++;
            $display("FAIL busy_ignore_hilo: got hi=%h lo=%h expected 0 0000000c", hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        do_op(MULT, 32'd1000, 32'd1000, "b2b_first");
        do_op(MULT, 32'hFFFFFFF0, 32'd3, "b2b_second");
        do_op(DIVU, 32'hFFFFFFFF, 32'd16, "b2b_third");
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: x = 32'h80000000;
                1: x = 32'hFFFFFFFF;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: y = 32'd0;
                1: y = 32'd1;
                2: y = 32'hFFFFFFFF;
                3: y = 32'h80000000;
                default: y = $urandom;
            endcase
            do_op(op, x, y, $sformatf("rand%0d_op%0d", i, op));
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_reset_mid_run();
        test_op_while_busy();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the EX stage of the `mips` five-stage pipeline. It accepts operands from the forwarded ID/EX register values and executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` over multiple cycles. Results are held in internal HI/LO registers. It drives `busy` to the hazard unit, which stalls any HI/LO instruction in ID while `busy` is high or a start is being issued.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: busy duration of `mult`/`multu`, in cycles; must be ≥1.
- `DIV_CYCLES`, default 10: busy duration of `div`/`divu`, in cycles; must be ≥1.

Ports:
- `clk`  input  1  system clock. One clock domain; every register updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `md_op`  input  3  operation code. 0 = NONE, 1 = MULT, 2 = MULTU, 3 = DIV, 4 = DIVU, 5 = MTHI, 6 = MTLO, 7 = reserved (treated as NONE).
- `a`  input  32  rs operand (forwarded).
- `b`  input  32  rt operand (forwarded).
- `busy`  output  1  high while a multiply or divide is in progress.
- `hi`  output  32  current HI register value.
- `lo`  output  32  current LO register value.

## Operation

- **Reset:** `busy`=0, `hi`=0, `lo`=0, internal counter=0, state=IDLE.
- **State machine:** IDLE and RUN.
  - **IDLE, md_op ∈ {1..4}:**
    - Latch the operation and compute the full 64-bit result into the pending registers.
    - Load the counter with MULT_CYCLES or DIV_CYCLES for the operation.
    - Go to RUN. `busy`=1 from the next cycle.
  - **IDLE, md_op = 5/6:** write `a` into HI/LO at this edge. `busy` stays 0.
  - **RUN:** decrement the counter each cycle. When counter = 1 at the edge:
    - Commit the pending result to HI/LO.
    - Clear `busy`.
    - Return to IDLE.
  - **RUN, any md_op:** ignored. The hazard unit guarantees none arrive; the block must not corrupt HI/LO or restart if one does.
- **Arithmetic:**
  - MULT: signed 32×32 → 64 bits. HI = product[63:32], LO = product[31:0].
  - MULTU: the same, unsigned.
  - DIV: signed, quotient truncated toward zero. LO = quotient, HI = remainder, which takes the sign of the dividend.
  - DIVU: unsigned; LO = quotient, HI = remainder.
  - DIV with 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divisor = 0 (DIV or DIVU): HI/LO keep their prior values. `busy` is still held for the full DIV_CYCLES.
- **HI/LO reads:** `hi`/`lo` are direct register outputs. mfhi/mflo in EX read them combinationally, which is valid once `busy`=0.
- **Reset during RUN:** abort. Next cycle `busy`=0, HI=LO=0, and the pending result is discarded.

## Timing

- Start edge E0 (md_op = MULT sampled): `busy`=1 during cycles E0+1 … E0+MULT_CYCLES.
- New HI/LO are visible in the same cycle `busy` falls (after edge E0+MULT_CYCLES). The same rule applies to divide with DIV_CYCLES.
- Back-to-back: a new op may be sampled in the first cycle `busy`=0.
- mthi/mtlo: new value is visible in the cycle after the sampling edge. `busy` stays 0.
- `busy` is registered with no combinational path from `md_op`. The hazard unit stalls on `busy | (md_op in EX ∈ 1..4)`.

## Test plan

- **Reset, then MULT:** reset 1 cycle; MULT with a=0xFFFFFFFF (−1), b=2 → `busy` high for exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE when `busy` falls.
- **MULTU:** a=0xFFFFFFFF, b=2 → HI=0x00000001, LO=0xFFFFFFFE. DIVU with a=7, b=2 → `busy` for 10 cycles; LO=3, HI=1.
- **Signed DIV:** a=−7 (0xFFFFFFF9), b=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). Overflow case a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero:** MTHI a=0x1234, then MTLO a=0x5678, then DIV b=0 → `busy` for 10 cycles; HI=0x1234, LO=0x5678 unchanged.
- **Reset mid-run:** assert reset on cycle 3 of a DIV → next cycle `busy`=0, HI=LO=0. A MULT issued after reset completes normally.
- **Op while busy:** drive MTHI a=0xDEAD during RUN of a MULT 3×4 → ignored; final HI=0, LO=12. Back-to-back MULT in the first idle cycle starts correctly.
